// File: rtl/rtc_lapwatch_if.sv
// Control/status bundle between the RTC bus wrapper (master) and the lap stopwatch (slave).
// The wrapper drives the i_* strobes and reads back the o_* status.
interface rtc_lapwatch_if #(
    parameter int LGLAPS = 2
);
    logic [31:0]     i_ckstep;
    logic            i_clear;
    logic            i_start;
    logic            i_stop;
    logic            i_mode;
    logic            i_load;
    logic [30:0]     i_load_value;
    logic            i_lap;
    logic            i_lap_rd;
    logic [30:0]     o_value;
    logic            o_running;
    logic [30:0]     o_lap_value;
    logic            o_lap_valid;
    logic [LGLAPS:0] o_lap_count;
    logic            o_lap_overflow;
    logic            o_expired;

    modport master (
        output i_ckstep, i_clear, i_start, i_stop, i_mode, i_load, i_load_value, i_lap, i_lap_rd,
        input  o_value, o_running, o_lap_value, o_lap_valid, o_lap_count, o_lap_overflow, o_expired
    );

    modport slave (
        input  i_ckstep, i_clear, i_start, i_stop, i_mode, i_load, i_load_value, i_lap, i_lap_rd,
        output o_value, o_running, o_lap_value, o_lap_valid, o_lap_count, o_lap_overflow, o_expired
    );
endinterface

// File: rtl/rtc_lapwatch.sv
// BCD stopwatch / countdown timer at 10 ms resolution with preload and a lap-capture FIFO.
// The 10 ms tick is the carry out of a 48-bit phase accumulator stepping by 100x the per-second step.
module rtc_lapwatch #(
    parameter int LGLAPS        = 2,
    parameter bit OPT_COUNTDOWN = 1'b1
) (
    input  logic          i_clk,
    input  logic          i_reset,
    rtc_lapwatch_if.slave bus
);
    localparam int DEPTH = 1 << LGLAPS;

    logic [47:0]       step_q, step_d;
    logic [47:0]       acc_q, acc_d;
    logic              tick_q, tick_d;
    logic              running_q, running_d;
    logic              mode_q, mode_d;
    logic              expired_q, expired_d;
    logic [30:0]       value_q, value_d;
    logic [30:0]       lap_mem_q [DEPTH];
    logic [30:0]       lap_mem_d [DEPTH];
    logic [LGLAPS-1:0] wr_ptr_q, wr_ptr_d;
    logic [LGLAPS-1:0] rd_ptr_q, rd_ptr_d;
    logic [LGLAPS:0]   count_q, count_d;
    logic              overflow_q, overflow_d;

    logic [48:0]       acc_sum;
    logic              start_go;
    logic              advance;
    logic              full;
    logic              pop;
    logic              push_req;
    logic              push;

    function automatic logic [3:0] digit_max(input int idx);
        if (idx == 3 || idx == 5) return 4'd5;
        if (idx == 7)             return 4'd7;
        return 4'd9;
    endfunction

    // One BCD count step; digits saturating at their limit ripple a carry (or borrow) upward.
    function automatic logic [30:0] bcd_step(input logic [30:0] v, input logic down);
        logic [31:0] w;
        logic [3:0]  d;
        logic [3:0]  lim;
        logic        carry;
        w     = {1'b0, v};
        carry = 1'b1;
        for (int i = 0; i < 8; i++) begin
            lim = digit_max(i);
            d   = w[4*i +: 4];
            if (carry) begin
                if (!down) begin
                    if (d == lim) begin
                        d = 4'd0;
                    end else begin
                        d     = d + 4'd1;
                        carry = 1'b0;
                    end
                end else begin
                    if (d == 4'd0) begin
                        d = lim;
                    end else begin
                        d     = d - 4'd1;
                        carry = 1'b0;
                    end
                end
            end
            w[4*i +: 4] = d;
        end
        return w[30:0];
    endfunction

    always_comb begin
        step_d = ({16'h0, bus.i_ckstep} << 6) + ({16'h0, bus.i_ckstep} << 5)
               + ({16'h0, bus.i_ckstep} << 2);
    end

    always_comb begin
        start_go = bus.i_start && !bus.i_stop && !running_q;
        advance  = running_q || start_go;
        acc_sum  = {1'b0, acc_q} + {1'b0, step_q};
        acc_d    = advance ? acc_sum[47:0] : acc_q;
        tick_d   = advance && acc_sum[48];
    end

    // A down-count tick that finds the value already at zero expires instead of borrowing.
    always_comb begin
        running_d = running_q;
        mode_d    = mode_q;
        value_d   = value_q;
        expired_d = 1'b0;
        if (bus.i_stop) begin
            running_d = 1'b0;
        end else if (start_go) begin
            running_d = 1'b1;
            mode_d    = OPT_COUNTDOWN ? bus.i_mode : 1'b0;
        end
        if (tick_q && running_q) begin
            if (mode_q && value_q == '0) begin
                expired_d = 1'b1;
                running_d = 1'b0;
            end else begin
                value_d = bcd_step(value_q, mode_q);
            end
        end
        if (bus.i_clear) begin
            value_d = '0;
        end else if (bus.i_load && !running_q) begin
            value_d = bus.i_load_value;
        end
    end

    always_comb begin
        full     = (count_q == (LGLAPS+1)'(DEPTH));
        pop      = bus.i_lap_rd && (count_q != '0);
        push_req = bus.i_lap && running_q;
        push     = push_req && (!full || pop);
    end

    // Lap FIFO: a simultaneous pop frees the slot, so a push to a full FIFO still lands.
    always_comb begin
        lap_mem_d  = lap_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (bus.i_clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                lap_mem_d[wr_ptr_q] = value_q;
                wr_ptr_d            = wr_ptr_q + LGLAPS'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + LGLAPS'(1);
            end
            if (push && !pop) begin
                count_d = count_q + (LGLAPS+1)'(1);
            end else if (!push && pop) begin
                count_d = count_q - (LGLAPS+1)'(1);
            end
            if (push_req && !push) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            step_q     <= '0;
            acc_q      <= '0;
            tick_q     <= 1'b0;
            running_q  <= 1'b0;
            mode_q     <= 1'b0;
            expired_q  <= 1'b0;
            value_q    <= '0;
            lap_mem_q  <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            step_q     <= step_d;
            acc_q      <= acc_d;
            tick_q     <= tick_d;
            running_q  <= running_d;
            mode_q     <= mode_d;
            expired_q  <= expired_d;
            value_q    <= value_d;
            lap_mem_q  <= lap_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    assign bus.o_value        = value_q;
    assign bus.o_running      = running_q;
    assign bus.o_lap_value    = lap_mem_q[rd_ptr_q];
    assign bus.o_lap_valid    = (count_q != '0);
    assign bus.o_lap_count    = count_q;
    assign bus.o_lap_overflow = overflow_q;
    assign bus.o_expired      = expired_q;
endmodule

// File: doc/rtc_lapwatch.md
Name: rtc_lapwatch

Overview:
- Parametrised BCD stopwatch and countdown timer for the wishbone RTC core.
- Runs at 10 ms resolution, derived from the RTC's 48-bit per-second phase step (bottom 32 bits supplied as i_ckstep).
- Extends the basic stopwatch with three features: a count-down mode with expiry pulse, a preload value, and a lap-capture FIFO of depth 2^LGLAPS with overflow flag.
- Sits beside the clock/timer/alarm blocks; the bus wrapper drives its control strobes and reads its outputs.

Parameters:
- LGLAPS, 2: log2 of lap FIFO depth (1..6).
- OPT_COUNTDOWN, 1: 1 enables down-count mode; 0 ties mode to up-count and o_expired to 0.

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_ckstep  in  32  per-clock phase step; a 48-bit accumulator stepping by {16'h0,i_ckstep} rolls over once per second
- i_clear  in  1  stop-independent clear of value, lap FIFO and overflow flag
- i_start  in  1  start strobe
- i_stop  in  1  stop strobe
- i_mode  in  1  0 = count up, 1 = count down; latched on i_start
- i_load  in  1  load i_load_value into the counter (honoured only while stopped)
- i_load_value  in  31  BCD preload value
- i_lap  in  1  capture current value into the lap FIFO
- i_lap_rd  in  1  pop the lap FIFO head
- o_value  out  31  current BCD value
- o_running  out  1  counter enabled
- o_lap_value  out  31  FIFO head (valid when o_lap_valid)
- o_lap_valid  out  1  FIFO not empty
- o_lap_count  out  LGLAPS+1  FIFO occupancy
- o_lap_overflow  out  1  sticky: a lap was dropped because the FIFO was full
- o_expired  out  1  one-cycle pulse on count-down reaching zero

Behaviour:
- Reset (async): every register is zero.
  - o_value=0, o_running=0, o_lap_valid=0, o_lap_count=0, o_lap_overflow=0, o_expired=0.
  - Accumulator and latched mode are also zero.
- BCD format:
  - [3:0] hundredths, [7:4] tenths.
  - [11:8] seconds units, [14:12] seconds tens (0-5), [15]=0.
  - [19:16] minutes units, [22:20] minutes tens (0-5), [23]=0.
  - [27:24] hours units, [30:28] hours tens (0-7).
- Tick generation:
  - A 48-bit accumulator adds 100*{16'h0,i_ckstep} (computed as shifts and adds, registered one stage) each cycle while running, or on the i_start cycle.
  - Carry-out produces a one-cycle internal tick.
  - When stopped, the accumulator holds its value; it is not cleared on stop.
- Counter update: on tick with running, o_value updates on the next clock edge. Carry/borrow may be pipelined one stage, but each tick produces exactly one increment or decrement.
- Up mode: 79:59:59.99 wraps to 00:00:00.00.
- Down mode:
  - Decrement with BCD borrows (seconds and minutes tens borrow to 5, hours to 79).
  - The tick on which the value is already 0 asserts o_expired for one cycle and clears running; the value stays 0.
  - Starting with the value at 0 expires on the first tick.
- Control priority: i_clear > i_stop > i_start.
  - i_clear zeroes value, FIFO and overflow; it does not change running.
  - Simultaneous i_stop and i_start stops.
  - i_start while running is ignored, and i_mode is not relatched.
- i_load: honoured only when not running and no i_clear; loads i_load_value verbatim. Digits out of range are the caller's error; no correction is performed.
- Lap capture:
  - i_lap while running pushes the o_value present in that cycle, i.e. the pre-tick value if a tick coincides.
  - i_lap while stopped is ignored.
  - Push while full with no pop drops the sample and sets o_lap_overflow.
  - Push and pop in the same cycle while full succeeds, and the count is unchanged.
  - Pop when empty is ignored.
  - o_lap_value is registered or first-word-fall-through; it is valid in the cycle o_lap_valid is high.
- OPT_COUNTDOWN=0: i_mode is ignored.

Test Plan:
- Reset mid-run (value 00:00:03.27, running, 2 laps stored) -> all outputs 0 immediately, asynchronously.
- i_ckstep=32'hFFFF_FFFF, start up mode -> ticks every 655/656 cycles; after 100 ticks o_value=31'h0000_0100. Preload 31'h7959_5999 and run 1 tick -> 0.
- Up mode with load 31'h0000_5999 (00:00:59.99), 1 tick -> 31'h0001_0000. Load 31'h0059_5999, 1 tick -> 31'h0100_0000.
- Down mode with load 31'h0001_0000, 1 tick -> 31'h0000_5999. Load 31'h0000_0002, run 3 ticks -> values 01, 00, then o_expired pulse, o_running=0, value 0.
- LGLAPS=2: five i_lap strobes while running -> o_lap_count=4, o_lap_overflow=1, values popped in order. Push+pop when full -> count stays 4, no new overflow.
- Same-cycle i_start+i_stop -> o_running=0. i_clear while running -> value 0, still running, FIFO empty, overflow cleared. i_load while running -> ignored.
